// File: rtl/cmplx_mult_pipe.sv
// cmplx_mult_pipe: pipelined fixed-point complex multiplier, P = A*B or A*conj(B).
// Registered input, products, rounded sums, then limited output with sticky ovf.
module cmplx_mult_pipe #(
  parameter int W     = 16,
  parameter int F     = 11,
  parameter int ROUND = 1,
  parameter int SAT   = 1
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                valid_in,
  input  logic                conj_b,
  input  logic signed [W-1:0] a_re,
  input  logic signed [W-1:0] a_im,
  input  logic signed [W-1:0] b_re,
  input  logic signed [W-1:0] b_im,
  output logic                valid_out,
  output logic signed [W-1:0] p_re,
  output logic signed [W-1:0] p_im,
  output logic                ovf,
  input  logic                clr_ovf
);

  localparam int PW = 2*W + 1;
  localparam int SW = 2*W + 2;

  localparam logic signed [SW-1:0] RND =
    (ROUND != 0) ? SW'(64'd1 << (F-1)) : '0;

  localparam logic [W-1:0] MAXV = {1'b0, {(W-1){1'b1}}};
  localparam logic [W-1:0] MINV = {1'b1, {(W-1){1'b0}}};

  // stage 1 state
  logic                v1;
  logic signed [W-1:0] ar1;
  logic signed [W-1:0] ai1;
  logic signed [W-1:0] br1;
  logic signed [W:0]   bi1;

  // stage 2 state
  logic                 v2;
  logic signed [PW-1:0] rr2;
  logic signed [PW-1:0] ii2;
  logic signed [PW-1:0] ri2;
  logic signed [PW-1:0] ir2;

  // stage 3 state
  logic                 v3;
  logic signed [SW-1:0] re3;
  logic signed [SW-1:0] im3;

  // comb nets
  logic signed [W:0]    bi_ext;
  logic signed [W:0]    bi_sel;
  logic signed [PW-1:0] ar_x;
  logic signed [PW-1:0] ai_x;
  logic signed [PW-1:0] br_x;
  logic signed [PW-1:0] bi_x;
  logic signed [SW-1:0] re_s;
  logic signed [SW-1:0] im_s;
  logic signed [SW-1:0] re_r;
  logic signed [SW-1:0] im_r;
  logic signed [SW-1:0] re_sh;
  logic signed [SW-1:0] im_sh;
  logic                 or_re;
  logic                 or_im;
  logic        [W-1:0]  lim_re;
  logic        [W-1:0]  lim_im;

  // conj(B) negates b_im one bit wider so -(-2^(W-1)) stays exact
  assign bi_ext = {b_im[W-1], b_im};
  assign bi_sel = conj_b ? -bi_ext : bi_ext;

  // stage 1: capture operands with the conjugate already applied
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      v1  <= 1'b0;
      ar1 <= '0;
      ai1 <= '0;
      br1 <= '0;
      bi1 <= '0;
    end else begin
      v1  <= valid_in;
      ar1 <= a_re;
      ai1 <= a_im;
      br1 <= b_re;
      bi1 <= bi_sel;
    end
  end

  assign ar_x = {{(W+1){ar1[W-1]}}, ar1};
  assign ai_x = {{(W+1){ai1[W-1]}}, ai1};
  assign br_x = {{(W+1){br1[W-1]}}, br1};
  assign bi_x = {{W{bi1[W]}}, bi1};

  // stage 2: the four partial products at full precision
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      v2  <= 1'b0;
      rr2 <= '0;
      ii2 <= '0;
      ri2 <= '0;
      ir2 <= '0;
    end else begin
      v2  <= v1;
      rr2 <= ar_x * br_x;
      ii2 <= ai_x * bi_x;
      ri2 <= ar_x * bi_x;
      ir2 <= ai_x * br_x;
    end
  end

  assign re_s  = {rr2[PW-1], rr2} - {ii2[PW-1], ii2};
  assign im_s  = {ri2[PW-1], ri2} + {ir2[PW-1], ir2};
  assign re_r  = re_s + RND;
  assign im_r  = im_s + RND;
  assign re_sh = re_r >>> F;
  assign im_sh = im_r >>> F;

  // stage 3: rounded and rescaled sums, still unlimited
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      v3  <= 1'b0;
      re3 <= '0;
      im3 <= '0;
    end else begin
      v3  <= v2;
      re3 <= re_sh;
      im3 <= im_sh;
    end
  end

  // in range when every bit above the W-bit sign matches it
  assign or_re = !((&re3[SW-1:W-1]) || !(|re3[SW-1:W-1]));
  assign or_im = !((&im3[SW-1:W-1]) || !(|im3[SW-1:W-1]));

  // clamp toward the sign of the wide value, or wrap
  always_comb begin
    lim_re = re3[W-1:0];
    lim_im = im3[W-1:0];
    if (SAT != 0 && or_re) lim_re = re3[SW-1] ? MINV : MAXV;
    if (SAT != 0 && or_im) lim_im = im3[SW-1] ? MINV : MAXV;
  end

  // output stage: hold last valid result, sticky ovf where set beats clear
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      valid_out <= 1'b0;
      p_re      <= '0;
      p_im      <= '0;
      ovf       <= 1'b0;
    end else begin
      valid_out <= v3;
      if (v3) begin
        p_re <= lim_re;
        p_im <= lim_im;
      end
      if (v3 && (or_re || or_im)) ovf <= 1'b1;
      else if (clr_ovf)           ovf <= 1'b0;
    end
  end

endmodule

// File: doc/cmplx_mult_pipe.md
Name: cmplx_mult_pipe

Overview:
- Parametrised, pipelined fixed-point complex multiplier for the IFFT processor.
- Computes P = A*B, or A*conj(B) when conj_b=1, on Q(W-F).F operands.
- Adds rounding, saturation, a sticky overflow flag and valid tracking.
- Used for twiddle-factor rotation between butterfly stages; accepts one sample per cycle, no stalls.

Parameters:
- W, 16: operand/result width (two's complement), W >= 4.
- F, 11: fraction bits, 1 <= F <= W-2 (default Q5.11).
- ROUND, 1: 1 = round-half-up (add 2^(F-1) before shift), 0 = truncate (floor).
- SAT, 1: 1 = saturate result to W bits, 0 = wrap (keep low W bits of the shifted sum).

Ports:
- clk  in  1  system clock, rising edge.
- rst  in  1  asynchronous, active-low reset.
- valid_in  in  1  input sample qualifier.
- conj_b  in  1  1 = use conj(B); sampled with valid_in.
- a_re, a_im  in  W each  signed operand A.
- b_re, b_im  in  W each  signed operand B.
- valid_out  out  1  result qualifier.
- p_re, p_im  out  W each  signed product.
- ovf  out  1  sticky: set when any valid result saturated/wrapped.
- clr_ovf  in  1  synchronous clear of ovf.

Behaviour:
- Reset (rst=0, async): all pipeline registers, valid_out, p_re, p_im and ovf go to 0 immediately. Outputs stay 0 until the first valid result emerges.
- Latency is fixed at 3 cycles: data sampled at edge N with valid_in=1 appears with valid_out=1 after edge N+3.
- Throughput is 1 per cycle. Valid is a shift bit travelling with the data.
- Bubbles (valid_in=0): valid_out=0 at the matching slot. Data registers may update freely; p_re/p_im hold their last valid value when valid_out=0.
- S1: register a, b and conj_b. If conj_b=1, b_im is negated at full precision (W+1 bits), so -(-2^(W-1)) does not overflow.
- S2: register the four products ar*br, ai*bi, ar*bi, ai*br, each 2W+1 bits signed.
- S3, full-precision sums (2W+2 bits):
  - re = ar*br - ai*bi'
  - im = ar*bi' + ai*br
  - bi' is the possibly negated b_im.
- S3, rounding: if ROUND=1 add 2^(F-1). Then arithmetic shift right by F.
- S3, limiting:
  - SAT=1: clamp to [-2^(W-1), 2^(W-1)-1].
  - SAT=0: take the low W bits.
  - An out-of-range condition on either component sets ovf in the same cycle valid_out asserts.
- ovf is sticky until clr_ovf=1 or reset.
  - clr_ovf coinciding with a new overflow: set wins, ovf stays 1.
  - Overflow in a bubble slot (valid=0) never sets ovf.
- Reset mid-stream: in-flight samples are discarded. No valid_out pulses appear for samples accepted before reset.
- No handshake back-pressure. The upstream block must tolerate the fixed latency.

Test Plan (W=16, F=11, ROUND=1, SAT=1 unless stated):
- Conjugate product: a=(0x0800, 0x0800), b=(0x0800, 0x0800), conj_b=1 -> after 3 cycles p=(0x1000, 0x0000), valid_out=1, ovf=0. Same inputs with conj_b=0 -> p=(0x0000, 0x1000).
- Rounding: a=(0x0001, 0), b=(0x0400, 0) -> p_re=0x0001. With ROUND=0 -> 0x0000. a=(0xFFFF, 0), b=(0x0400, 0): ROUND=1 -> 0x0000, ROUND=0 -> 0xFFFF.
- Saturation:
  - a=(0x7FFF, 0x7FFF), b=(0x7FFF, 0x8001), conj_b=0 -> p_re=0x7FFF, p_im=0x0000, ovf=1.
  - ovf holds through later clean samples until a clr_ovf pulse, then reads 0.
  - Repeat with SAT=0 -> p_re = low 16 bits of the shifted sum, ovf=1.
- Streaming: 8 back-to-back random samples, then a bubble, then 4 more -> outputs match the golden model in order, each exactly 3 cycles later; valid_out pattern is 8 ones, one zero, 4 ones.
- Reset mid-stream: assert rst=0 for 1 cycle after 2 of 3 samples accepted -> valid_out, p_re, p_im and ovf drop to 0 asynchronously; no stale valid_out after rst release.
- Corner: a=(0x8000, 0x8000), b=(0x8000, 0x8000), conj_b=1 -> p_re=0x7FFF, ovf=1 (real sum +2^31 >> 11 exceeds max), p_im=0x0000; checks full-precision negation.
